// File: rtl/seg_led_bus_port.sv
// -----------------------------------------------------------------------------
// seg_led_bus_port
//   Bus-mapped display peripheral: three CPU-writable registers (VALUE, LED,
//   CTRL) driving the board LEDs and a time-multiplexed 4-digit seven-segment
//   display. A per-frame shadow copy of VALUE keeps a frame from tearing when
//   the CPU rewrites VALUE mid-scan.
//
//   Optional feature macro: SEG_LZ_BLANK_EN
//     defined   -> leading-zero blanking of digits 3..1 based on the shadow
//     undefined -> all digits shown unless blanked through CTRL
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-low
//   bus_cs       in   chip select
//   bus_we       in   write enable (qualified by bus_cs)
//   bus_addr     in   0 = VALUE, 1 = LED, 2 = CTRL, 3 = reserved
//   bus_wdata    in   write data (RDATA_W bits)
//   bus_rdata    out  registered read data (RDATA_W bits)
//   bus_ready    out  one-cycle-latency acknowledge for every bus_cs cycle
//   led_data     out  LED drive, active-high
//   segment_data out  {dp,g,f,e,d,c,b,a}, active-low
//   AN           out  digit anodes, active-low, AN[0] = rightmost digit
//
// Parameters
//   DIV_W    refresh counter width; digit advances every 2^DIV_W clocks
//   RDATA_W  bus data width (>= 16)
// -----------------------------------------------------------------------------
module seg_led_bus_port #(
    parameter int DIV_W   = 16,
    parameter int RDATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_cs,
    input  logic               bus_we,
    input  logic [1:0]         bus_addr,
    input  logic [RDATA_W-1:0] bus_wdata,
    output logic [RDATA_W-1:0] bus_rdata,
    output logic               bus_ready,
    output logic [7:0]         led_data,
    output logic [7:0]         segment_data,
    output logic [3:0]         AN
);

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_LED   = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [15:0]        r_value;
    logic [15:0]        r_shadow;
    logic [7:0]         r_led;
    logic [7:0]         r_ctrl;
    logic [DIV_W-1:0]   r_cnt;
    logic [1:0]         r_idx;
    logic [RDATA_W-1:0] r_rdata;
    logic               r_ready;
    logic [3:0]         r_an;
    logic [7:0]         r_seg;

    logic               w_wr;
    logic               w_rd;
    logic               w_cnt_wrap;
    logic               w_frame_end;
    logic [RDATA_W-1:0] w_rd_value;
    logic [3:0]         w_lz_blank;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [3:0]         w_an_next;
    logic [7:0]         w_seg_next;

    assign w_wr        = bus_cs & bus_we;
    assign w_rd        = bus_cs & ~bus_we;
    assign w_cnt_wrap  = (r_cnt == {DIV_W{1'b1}});
    // The digit index moves 3->0 on this edge, closing the frame.
    assign w_frame_end = w_cnt_wrap & (r_idx == 2'd3);

    // Write data above bit 15 never reaches a register.
    generate
        if (RDATA_W > 16) begin : g_wdata_hi
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = ^bus_wdata[RDATA_W-1:16];
        end
    endgenerate

`ifdef SEG_LZ_BLANK_EN
    // Digit n (3..1) goes dark when shadow nibbles n..3 are all zero.
    assign w_lz_blank = {(r_shadow[15:12] == 4'h0),
                         (r_shadow[15:8]  == 8'h00),
                         (r_shadow[15:4]  == 12'h000),
                         1'b0};
`else
    assign w_lz_blank = 4'b0000;
`endif

    // Read-data selection for the addressed register (reserved reads as zero).
    always_comb begin
        w_rd_value = {RDATA_W{1'b0}};
        case (bus_addr)
            ADDR_VALUE: w_rd_value = RDATA_W'(r_value);
            ADDR_LED:   w_rd_value = RDATA_W'(r_led);
            ADDR_CTRL:  w_rd_value = RDATA_W'(r_ctrl);
            default:    w_rd_value = {RDATA_W{1'b0}};
        endcase
    end

    // Next display drive for the digit currently selected by the index.
    always_comb begin
        w_nibble   = r_shadow[{r_idx, 2'b00} +: 4];
        w_blank    = r_ctrl[{1'b1, r_idx}] | w_lz_blank[r_idx];
        w_an_next  = 4'b1111;
        w_seg_next = 8'hFF;
        if (w_blank) begin
            w_an_next  = 4'b1111;
            w_seg_next = 8'hFF;
        end else begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = {~r_ctrl[{1'b0, r_idx}], hex_to_seg(w_nibble)};
        end
    end

    // CPU-writable registers; writes to the reserved address are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= 16'h0000;
            r_led   <= 8'h00;
            r_ctrl  <= 8'h00;
        end else if (w_wr) begin
            case (bus_addr)
                ADDR_VALUE: r_value <= bus_wdata[15:0];
                ADDR_LED:   r_led   <= bus_wdata[7:0];
                ADDR_CTRL:  r_ctrl  <= bus_wdata[7:0];
                default:    r_value <= r_value;
            endcase
        end
    end

    // Registered read data and one-cycle access acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= {RDATA_W{1'b0}};
            r_ready <= 1'b0;
        end else begin
            r_ready <= bus_cs;
            if (w_rd) begin
                r_rdata <= w_rd_value;
            end
        end
    end

    // Free-running refresh counter and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {DIV_W{1'b0}};
            r_idx <= 2'd0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
            if (w_cnt_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Frame shadow: a coincident VALUE write is seen only from the next frame,
    // since the shadow samples the pre-edge register value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= 16'h0000;
        end else if (w_frame_end) begin
            r_shadow <= r_value;
        end
    end

    // Output stage; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus_rdata    = r_rdata;
    assign bus_ready    = r_ready;
    assign led_data     = r_led;
    assign segment_data = r_seg;
    assign AN           = r_an;

endmodule

// File: tb/tb_seg_led_bus_port.sv
module tb_seg_led_bus_port;

    localparam int DIV_W   = 2;
    localparam int RDATA_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               bus_cs;
    logic               bus_we;
    logic [1:0]         bus_addr;
    logic [RDATA_W-1:0] bus_wdata;
    logic [RDATA_W-1:0] bus_rdata;
    logic               bus_ready;
    logic [7:0]         led_data;
    logic [7:0]         segment_data;
    logic [3:0]         AN;

    int n_checks = 0;
    int n_pass   = 0;

    seg_led_bus_port #(.DIV_W(DIV_W), .RDATA_W(RDATA_W)) dut (
        .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .led_data(led_data),
        .segment_data(segment_data), .AN(AN)
    );

    always #5 clk = ~clk;

    // Seven-segment patterns straight from the hex table (dp off).
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // ---------------- reference model ----------------
    // Timing is derived from the edge count since reset release: 4 clocks per
    // digit, 16 per frame, shadow reloaded at every 16th edge.
    int unsigned  m_edges;
    logic [15:0]  m_value, m_shadow;
    logic [7:0]   m_led, m_ctrl;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic [3:0]   m_an;
    logic [7:0]   m_seg;
    int           m_dig;

    function automatic logic lz_blank(input logic [15:0] sh, input int d);
`ifdef SEG_LZ_BLANK_EN
        return (d != 0) && ((sh >> (4 * d)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] exp_disp(input int unsigned edges, input logic [15:0] sh,
                                             input logic [7:0] ctrl);
        int         d;
        logic [3:0] nib;
        logic [7:0] pat;
        d   = int'((edges / 4) % 4);
        nib = 4'((sh >> (4 * d)) & 16'h000F);
        pat = seg_tab[nib];
        if (ctrl[4 + d] || lz_blank(sh, d)) return 12'hFFF;
        return {~(4'b0001 << d), ~ctrl[d], pat[6:0]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges  <= 0;
            m_value  <= 16'h0000;
            m_shadow <= 16'h0000;
            m_led    <= 8'h00;
            m_ctrl   <= 8'h00;
            m_rdata  <= 32'h0;
            m_ready  <= 1'b0;
            m_an     <= 4'hF;
            m_seg    <= 8'hFF;
            m_dig    <= 0;
        end else begin
            m_dig <= int'((m_edges / 4) % 4);
            {m_an, m_seg} <= exp_disp(m_edges, m_shadow, m_ctrl);
            if (((m_edges + 1) % 16) == 0) m_shadow <= m_value;
            if (bus_cs && bus_we) begin
                if (bus_addr == 2'd0) m_value <= bus_wdata[15:0];
                if (bus_addr == 2'd1) m_led   <= bus_wdata[7:0];
                if (bus_addr == 2'd2) m_ctrl  <= bus_wdata[7:0];
            end
            if (bus_cs && !bus_we) begin
                if (bus_addr == 2'd0)      m_rdata <= {16'h0, m_value};
                else if (bus_addr == 2'd1) m_rdata <= {24'h0, m_led};
                else if (bus_addr == 2'd2) m_rdata <= {24'h0, m_ctrl};
                else                       m_rdata <= 32'h0;
            end
            m_ready <= bus_cs;
            m_edges <= m_edges + 1;
        end
    end

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic drive(input logic cs, input logic we, input logic [1:0] a, input logic [31:0] d);
        bus_cs = cs; bus_we = we; bus_addr = a; bus_wdata = d;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 20; i++) begin
            if ((m_edges % 16) == p) break;
            @(negedge clk);
        end
    endtask

    function automatic logic [11:0] digit_of(input int d, input logic [7:0] pat);
        return {~(4'b0001 << d), pat};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({AN, segment_data, bus_ready, led_data, bus_rdata} !== {4'hF, 8'hFF, 1'b0, 8'h00, 32'h0}) begin
            $display("FAIL reset_state: got AN=%b seg=%h rdy=%b led=%h rd=%h, want 1111 ff 0 00 0",
                     AN, segment_data, bus_ready, led_data, bus_rdata);
        end else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({AN, segment_data} !== {4'b1110, 8'hC0}) begin
            $display("FAIL reset_first_digit: got AN=%b seg=%h, want 1110 c0", AN, segment_data);
        end else n_pass++;
    endtask

    task automatic test_value_frame();
        logic [7:0] pats [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
        wait_phase(4);
        drive(1'b1, 1'b1, 2'd0, 32'h0000_1A3F);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        wait_phase(0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if ({AN, segment_data} !== digit_of(i / 4, pats[i / 4])) begin
                $display("FAIL frame_1a3f[%0d]: got AN=%b seg=%h, want %h", i, AN, segment_data,
                         digit_of(i / 4, pats[i / 4]));
            end else n_pass++;
        end
    endtask

    task automatic test_shadow_boundary();
        logic [7:0] old_pats [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
        logic [11:0] want;
        wait_phase(15);
        drive(1'b1, 1'b1, 2'd0, 32'h0000_5555);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            want = (i < 16) ? digit_of(i / 4, old_pats[i / 4]) : digit_of((i - 16) / 4, 8'h92);
            n_checks++;
            if ({AN, segment_data} !== want) begin
                $display("FAIL shadow_edge[%0d]: got AN=%b seg=%h, want %h", i, AN, segment_data, want);
            end else n_pass++;
        end
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        n_checks++;
        if ({bus_ready, bus_rdata} !== {1'b1, 32'h0000_5555}) begin
            $display("FAIL value_readback: got rdy=%b rd=%h, want 1 00005555", bus_ready, bus_rdata);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_ready !== 1'b0) begin
            $display("FAIL ready_drop: got %b, want 0", bus_ready);
        end else n_pass++;
    endtask

    task automatic test_ctrl();
        logic [11:0] want;
        drive(1'b1, 1'b1, 2'd2, 32'hFFFF_FF21);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        n_checks++;
        if (bus_rdata !== 32'h0000_0021) begin
            $display("FAIL ctrl_readback: got %h, want 00000021", bus_rdata);
        end else n_pass++;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (m_dig == 0)      want = {4'b1110, 8'h12};
            else if (m_dig == 1) want = 12'hFFF;
            else                 want = digit_of(m_dig, 8'h92);
            n_checks++;
            if ({AN, segment_data} !== want) begin
                $display("FAIL ctrl_digit%0d: got AN=%b seg=%h, want %h", m_dig, AN, segment_data, want);
            end else n_pass++;
        end
        drive(1'b1, 1'b1, 2'd2, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 2'd1, 32'h0000_00A5);
        @(negedge clk);
        n_checks++;
        if ({led_data, bus_ready} !== {8'hA5, 1'b1}) begin
            $display("FAIL b2b_write: got led=%h rdy=%b, want a5 1", led_data, bus_ready);
        end else n_pass++;
        drive(1'b1, 1'b0, 2'd1, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({bus_rdata, bus_ready} !== {32'h0000_00A5, 1'b1}) begin
            $display("FAIL b2b_read_led: got rd=%h rdy=%b, want 000000a5 1", bus_rdata, bus_ready);
        end else n_pass++;
        drive(1'b1, 1'b0, 2'd3, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        n_checks++;
        if ({bus_rdata, bus_ready} !== {32'h0, 1'b1}) begin
            $display("FAIL b2b_read_rsvd: got rd=%h rdy=%b, want 0 1", bus_rdata, bus_ready);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_ready !== 1'b0) begin
            $display("FAIL b2b_ready_end: got %b, want 0", bus_ready);
        end else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            @(negedge clk);
            n_checks++;
            if ({AN, segment_data, led_data, bus_ready, bus_rdata} !== {m_an, m_seg, m_led, m_ready, m_rdata}) begin
                $display("FAIL random[%0d]: got AN=%b seg=%h led=%h rdy=%b rd=%h, want AN=%b seg=%h led=%h rdy=%b rd=%h",
                         i, AN, segment_data, led_data, bus_ready, bus_rdata, m_an, m_seg, m_led, m_ready, m_rdata);
            end else n_pass++;
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic test_leading_zero();
        logic [11:0] want;
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        drive(1'b1, 1'b1, 2'd2, 32'h0);
        @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            wait_phase(4);
            drive(1'b1, 1'b1, 2'd0, {16'h0, vals[v]});
            @(negedge clk);
            drive(1'b0, 1'b0, 2'd0, 32'h0);
            wait_phase(0);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
`ifdef SEG_LZ_BLANK_EN
                if (v == 0) begin
                    if (i / 4 >= 2)      want = 12'hFFF;
                    else if (i / 4 == 1) want = digit_of(1, 8'h99);
                    else                 want = digit_of(0, 8'hA4);
                end else begin
                    want = (i / 4 == 0) ? digit_of(0, 8'hC0) : 12'hFFF;
                end
`else
                if (v == 0) begin
                    if (i / 4 >= 2)      want = digit_of(i / 4, 8'hC0);
                    else if (i / 4 == 1) want = digit_of(1, 8'h99);
                    else                 want = digit_of(0, 8'hA4);
                end else begin
                    want = digit_of(i / 4, 8'hC0);
                end
`endif
                n_checks++;
                if ({AN, segment_data} !== want || {AN, segment_data} !== {m_an, m_seg}) begin
                    $display("FAIL lz_%h[%0d]: got AN=%b seg=%h, want %h", vals[v], i, AN, segment_data, want);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 2'd1, 32'h0000_003C);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd0, 32'h0000_1A3F);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        wait_phase(6);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({AN, segment_data, bus_ready, led_data, bus_rdata} !== {4'hF, 8'hFF, 1'b0, 8'h00, 32'h0}) begin
            $display("FAIL reset_mid: got AN=%b seg=%h rdy=%b led=%h rd=%h, want 1111 ff 0 00 0",
                     AN, segment_data, bus_ready, led_data, bus_rdata);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({AN, segment_data} !== {4'b1110, 8'hC0}) begin
            $display("FAIL reset_mid_restart: got AN=%b seg=%h, want 1110 c0", AN, segment_data);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_value_frame();
        test_shadow_boundary();
        test_ctrl();
        test_back_to_back();
        test_random();
        test_leading_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
